// File: rtl/hall_period_meter_if.sv
// Signal bundle between the hall sensor pin side and the period meter.
// The master drives the raw sensor level; the slave (the meter) returns the measurement.
interface hall_period_meter_if #(
    parameter int W = 32
);
    logic         hall;
    logic         detected;
    logic         rejected;
    logic [W-1:0] speed_data;
    logic [W-1:0] speed_avg;
    logic         valid;
    logic         avg_valid;
    logic         stalled;

    modport master (
        output hall,
        input  detected, rejected, speed_data, speed_avg, valid, avg_valid, stalled
    );

    modport slave (
        input  hall,
        output detected, rejected, speed_data, speed_avg, valid, avg_valid, stalled
    );
endinterface

// File: rtl/hall_period_meter.sv
// Rotor period meter: synchronises and glitch-filters the active-low hall input,
// times accepted falling edges, detects stalls and keeps a moving average of periods.
//
//  state    | meaning
//  ACQUIRE  | counter idle, waiting for a first falling edge to start timing
//  RUN      | counter running, edges are accepted/rejected, timeout declares a stall
module hall_period_meter #(
    parameter int W          = 32,
    parameter int FILTER_LEN = 4,
    parameter int MIN_PERIOD = 1000,
    parameter int TIMEOUT    = 50_000_000,
    parameter int AVG_LOG2   = 3
) (
    input  logic                clk,
    input  logic                nrst,
    hall_period_meter_if.slave  hall_bus
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int RUN_W  = $clog2(FILTER_LEN + 1);
    localparam int SUM_W  = W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    localparam logic [0:0] S_ACQUIRE = 1'b0;
    localparam logic [0:0] S_RUN     = 1'b1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_prev_filt;
    logic [RUN_W-1:0] r_run;

    logic [0:0]       r_state;
    logic [W-1:0]     r_cnt;
    logic             r_detected;
    logic             r_rejected;
    logic [W-1:0]     r_speed;
    logic [W-1:0]     r_avg;
    logic             r_valid;
    logic             r_avg_valid;
    logic             r_stalled;

    logic [W-1:0]        r_ring [DEPTH];
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic [SUM_W-1:0]    r_sum;
    logic [FILL_W-1:0]   r_fill;

    logic             w_fall;
    logic             w_accept;
    logic             w_reject;
    logic             w_stall;
    logic             w_full_next;
    logic [SUM_W-1:0] w_sum_next;

    // Level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_filt      <= 1'b1;
            r_prev_filt <= 1'b1;
            r_run       <= '0;
        end else begin
            r_sync1     <= hall_bus.hall;
            r_sync2     <= r_sync1;
            r_prev_filt <= r_filt;
            if (r_sync2 != r_filt) begin
                if (r_run == RUN_W'(FILTER_LEN - 1)) begin
                    r_filt <= r_sync2;
                    r_run  <= '0;
                end else begin
                    r_run <= r_run + 1'b1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign w_fall      = r_prev_filt & ~r_filt;
    assign w_accept    = (r_state == S_RUN) && w_fall && (r_cnt >= W'(MIN_PERIOD));
    assign w_reject    = (r_state == S_RUN) && w_fall && (r_cnt <  W'(MIN_PERIOD));
    assign w_stall     = (r_state == S_RUN) && (r_cnt == W'(TIMEOUT)) && !w_accept;
    assign w_full_next = (r_fill >= FILL_W'(DEPTH - 1));
    assign w_sum_next  = r_sum + SUM_W'(r_cnt) - SUM_W'(r_ring[r_wr_ptr]);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_ACQUIRE;
            r_cnt       <= '0;
            r_detected  <= 1'b0;
            r_rejected  <= 1'b0;
            r_speed     <= '0;
            r_avg       <= '0;
            r_valid     <= 1'b0;
            r_avg_valid <= 1'b0;
            r_stalled   <= 1'b1;
        end else begin
            r_detected <= w_accept;
            r_rejected <= w_reject;
            case (r_state)
                S_ACQUIRE: begin
                    if (w_fall) begin
                        r_cnt   <= W'(1);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt     <= W'(1);
                        r_speed   <= r_cnt;
                        r_valid   <= 1'b1;
                        r_stalled <= 1'b0;
                        if (w_full_next) begin
                            r_avg       <= w_sum_next[SUM_W-1:AVG_LOG2];
                            r_avg_valid <= 1'b1;
                        end
                    end else if (w_stall) begin
                        r_cnt       <= '0;
                        r_stalled   <= 1'b1;
                        r_valid     <= 1'b0;
                        r_avg_valid <= 1'b0;
                        r_state     <= S_ACQUIRE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_ACQUIRE;
            endcase
        end
    end

    // Running sum tracks the ring contents so the mean needs no adder tree.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
        end else if (w_accept) begin
            r_ring[r_wr_ptr] <= r_cnt;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
            r_sum            <= w_sum_next;
            if (r_fill != FILL_W'(DEPTH)) r_fill <= r_fill + 1'b1;
        end else if (w_stall) begin
            for (int i = 0; i < DEPTH; i++) r_ring[i] <= '0;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_fill   <= '0;
        end
    end

    assign hall_bus.detected   = r_detected;
    assign hall_bus.rejected   = r_rejected;
    assign hall_bus.speed_data = r_speed;
    assign hall_bus.speed_avg  = r_avg;
    assign hall_bus.valid      = r_valid;
    assign hall_bus.avg_valid  = r_avg_valid;
    assign hall_bus.stalled    = r_stalled;
endmodule

// File: tb/tb_hall_period_meter.sv
// Directed bench for hall_period_meter: table of edge steps plus hand sequences for
// stall timing, filter latency and mid-period reset.
module tb_hall_period_meter;
    localparam int W = 32;

    logic clk;
    logic nrst;

    hall_period_meter_if #(.W(W)) bus ();

    hall_period_meter #(
        .W(W), .FILTER_LEN(4), .MIN_PERIOD(100), .TIMEOUT(10000), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .nrst(nrst), .hall_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          low_len;
        int          gap;
        int          det;
        int          rej;
        logic [31:0] speed;
        logic        valid;
        logic        stalled;
        logic        avgv;
        logic [31:0] avg;
    } vec_t;

    vec_t tbl [20];

    int n_checks = 0;
    int n_fail   = 0;
    int det_cnt  = 0;
    int rej_cnt  = 0;
    int cyc      = 0;
    int last_det_cyc = 0;
    int stall_cyc    = 0;
    logic prev_stall = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.detected) begin
            det_cnt++;
            last_det_cyc = cyc;
        end
        if (bus.rejected) rej_cnt++;
        if (bus.stalled && !prev_stall) stall_cyc = cyc;
        prev_stall = bus.stalled;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Falls are spaced exactly 'gap' cycles apart when steps run back to back.
    task automatic do_edge(input int low_len, input int gap);
        bus.hall = 1'b0;
        repeat (low_len) @(negedge clk);
        bus.hall = 1'b1;
        repeat (gap - low_len) @(negedge clk);
        #1;
    endtask

    task automatic run_step(input int i);
        int d0, r0;
        d0 = det_cnt;
        r0 = rej_cnt;
        do_edge(tbl[i].low_len, tbl[i].gap);
        check($sformatf("s%0d detected", i), det_cnt - d0, tbl[i].det);
        check($sformatf("s%0d rejected", i), rej_cnt - r0, tbl[i].rej);
        check($sformatf("s%0d speed_data", i), bus.speed_data, tbl[i].speed);
        check($sformatf("s%0d valid", i), bus.valid, tbl[i].valid);
        check($sformatf("s%0d stalled", i), bus.stalled, tbl[i].stalled);
        check($sformatf("s%0d avg_valid", i), bus.avg_valid, tbl[i].avgv);
        check($sformatf("s%0d speed_avg", i), bus.speed_avg, tbl[i].avg);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " detected"}, bus.detected, 0);
        check({tag, " rejected"}, bus.rejected, 0);
        check({tag, " speed_data"}, bus.speed_data, 0);
        check({tag, " speed_avg"}, bus.speed_avg, 0);
        check({tag, " valid"}, bus.valid, 0);
        check({tag, " avg_valid"}, bus.avg_valid, 0);
        check({tag, " stalled"}, bus.stalled, 1);
    endtask

    initial begin
        int d0;
        int k;
        bit found;

        //              low  gap   det rej speed valid stl avgv avg
        tbl[0]  = '{8, 1000,  0, 0,    0, 0, 1, 0,    0};
        tbl[1]  = '{8, 1000,  1, 0, 1000, 1, 0, 0,    0};
        tbl[2]  = '{8, 1000,  1, 0, 1000, 1, 0, 0,    0};
        tbl[3]  = '{8, 1000,  1, 0, 1000, 1, 0, 0,    0};
        tbl[4]  = '{8, 1000,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[5]  = '{8,  400,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[6]  = '{1,  300,  0, 0, 1000, 1, 0, 1, 1000};
        tbl[7]  = '{3,  300,  0, 0, 1000, 1, 0, 1, 1000};
        tbl[8]  = '{4, 1000,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[9]  = '{8,   50,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[10] = '{8,  950,  0, 1, 1000, 1, 0, 1, 1000};
        tbl[11] = '{8, 1000,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[12] = '{8, 2000,  1, 0, 1000, 1, 0, 1, 1000};
        tbl[13] = '{8, 3000,  1, 0, 2000, 1, 0, 1, 1250};
        tbl[14] = '{8, 4000,  1, 0, 3000, 1, 0, 1, 1750};
        tbl[15] = '{8, 5000,  1, 0, 4000, 1, 0, 1, 2500};
        tbl[16] = '{8, 1000,  1, 0, 5000, 1, 0, 1, 3500};
        tbl[17] = '{8, 10020, 1, 0, 1000, 0, 1, 0, 3250};
        tbl[18] = '{8, 1000,  0, 0, 1000, 0, 1, 0, 3250};
        tbl[19] = '{8, 1000,  1, 0, 1000, 1, 0, 0, 3250};

        bus.hall = 1'b1;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 18; i++) run_step(i);
        check("stall delay after accept", stall_cyc - last_det_cyc, 10000);
        for (int i = 18; i < 20; i++) run_step(i);

        // Mid-period reset.
        repeat (300) @(negedge clk);
        nrst = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        #1;

        d0 = det_cnt;
        do_edge(8, 1000);
        check("post-reset first edge detected", det_cnt - d0, 0);
        check("post-reset first edge stalled", bus.stalled, 1);

        // Raw low first sampled at edge N -> detected visible after edge N+FILTER_LEN+2.
        bus.hall = 1'b0;
        k = 0;
        found = 1'b0;
        for (int j = 0; j < 50 && !found; j++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.detected) found = 1'b1;
        end
        check("latency detected seen", found, 1);
        check("latency edges", k, 7);
        check("post-reset speed_data", bus.speed_data, 1000);
        check("post-reset valid", bus.valid, 1);
        check("post-reset stalled", bus.stalled, 0);
        repeat (4) @(negedge clk);
        bus.hall = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
